// File: rtl/press_decoder.sv
// Press decoder: synchronizes the debounced button pulse and classifies
// each press as single or double for lab-board step/run control.
module press_decoder #(
    parameter int WINDOW_CYCLES = 50_000_000,
    parameter int CNT_W         = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       press_in,
    output logic       single_press,
    output logic       double_press,
    output logic       step_en,
    output logic       run_mode,
    output logic [7:0] press_count,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        WAIT2 = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             s3;
    logic             press_edge;
    state_t           state;
    logic [CNT_W-1:0] timer;

    // press_in comes from a divided clock, so treat it as asynchronous
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= press_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign press_edge = s2 & ~s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            timer        <= '0;
            single_press <= 1'b0;
            double_press <= 1'b0;
            step_en      <= 1'b0;
            run_mode     <= 1'b0;
            press_count  <= 8'd0;
            busy         <= 1'b0;
        end else begin
            single_press <= 1'b0;
            double_press <= 1'b0;
            step_en      <= 1'b0;

            if (press_edge) begin
                press_count <= press_count + 8'd1;
            end

            unique case (state)
                IDLE: begin
                    if (press_edge) begin
                        state <= WAIT2;
                        timer <= '0;
                        busy  <= 1'b1;
                    end
                end
                WAIT2: begin
                    timer <= timer + CNT_W'(1);
                    // an edge on the timeout cycle still counts as a double
                    if (press_edge) begin
                        double_press <= 1'b1;
                        run_mode     <= ~run_mode;
                        state        <= IDLE;
                        timer        <= '0;
                        busy         <= 1'b0;
                    end else if (timer == LAST) begin
                        single_press <= 1'b1;
                        step_en      <= ~run_mode;
                        state        <= IDLE;
                        timer        <= '0;
                        busy         <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_press_decoder.sv
// Scoreboard bench for press_decoder: timestamp-based reference model,
// directed scenarios plus randomized press trains.
module tb_press_decoder;

    localparam int W = 20;

    logic       clk;
    logic       rst_n;
    logic       press_in;
    logic       single_press;
    logic       double_press;
    logic       step_en;
    logic       run_mode;
    logic [7:0] press_count;
    logic       busy;

    press_decoder #(
        .WINDOW_CYCLES(W),
        .CNT_W        (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .press_in    (press_in),
        .single_press(single_press),
        .double_press(double_press),
        .step_en     (step_en),
        .run_mode    (run_mode),
        .press_count (press_count),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit sgl;
        bit dbl;
        bit stp;
    } ev_t;

    ev_t sbq[$];
    ev_t me;
    int  edges[$];
    int  cyc;
    bit  prev;
    bit  open;
    int  e_open;
    bit  m_run;
    int  m_cnt;
    int  tests;
    int  fails;

    // Reference: a press rise sampled at cycle N becomes an edge at N+2;
    // a window opened at E closes with a single at E+W unless an edge
    // arrives at or before E+W.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0;
            prev = 1'b0;
            edges.delete();
            open = 1'b0;
            e_open = 0;
            m_run = 1'b0;
            m_cnt = 0;
            sbq.delete();
        end else begin
            cyc++;
            if (press_in && !prev) edges.push_back(cyc + 2);
            prev = press_in;
            if (edges.size() > 0 && edges[0] == cyc) begin
                void'(edges.pop_front());
                m_cnt = (m_cnt + 1) % 256;
                if (open) begin
                    sbq.push_back('{cyc, 1'b0, 1'b1, 1'b0});
                    m_run = !m_run;
                    open = 1'b0;
                end else begin
                    open = 1'b1;
                    e_open = cyc;
                end
            end else if (open && cyc == e_open + W) begin
                sbq.push_back('{cyc, 1'b1, 1'b0, !m_run});
                open = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            tests++;
            if (busy !== open) begin
                fails++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, open);
            end
            tests++;
            if (press_count !== 8'(m_cnt)) begin
                fails++;
                $display("FAIL press_count cyc=%0d got=%0d exp=%0d",
                         cyc, press_count, m_cnt);
            end
            tests++;
            if (run_mode !== m_run) begin
                fails++;
                $display("FAIL run_mode cyc=%0d got=%b exp=%b",
                         cyc, run_mode, m_run);
            end
            if (single_press || double_press || step_en ||
                (sbq.size() > 0 && sbq[0].cyc <= cyc)) begin
                me = '{cyc, 1'b0, 1'b0, 1'b0};
                if (sbq.size() > 0 && sbq[0].cyc <= cyc) me = sbq.pop_front();
                tests++;
                if ({single_press, double_press, step_en} !==
                    {me.sgl, me.dbl, me.stp} || me.cyc != cyc) begin
                    fails++;
                    $display("FAIL event cyc=%0d got s/d/st=%b%b%b exp=%b%b%b@%0d",
                             cyc, single_press, double_press, step_en,
                             me.sgl, me.dbl, me.stp, me.cyc);
                end
            end
        end
    end

    task automatic press(input int hi, input int lo);
        press_in = 1'b1;
        repeat (hi) @(negedge clk);
        press_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic mid_reset(input string name);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk(name, int'({single_press, double_press, step_en,
                        run_mode, press_count, busy}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        press_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        press(3, 30);
        mid_reset("async_reset");

        // single press: long pulse, one event
        press(50, 40);
        chk("single_count", press_count, 1);

        // double press then a single that must not step
        press(5, 5);
        press(5, 40);
        chk("double_run", run_mode, 1);
        chk("double_count", press_count, 3);
        press(5, 40);

        // boundary: edge on the timeout cycle, then one cycle later
        press(5, 15);
        press(5, 40);
        press(5, 16);
        press(5, 60);

        // reset in the middle of an open window
        press(2, 5);
        mid_reset("reset_mid_window");
        chk("reset_busy", busy, 0);
        press(3, 40);
        chk("fresh_count", press_count, 1);

        // wrap of press_count and of run_mode
        mid_reset("reset_before_wrap");
        for (int i = 0; i < 256; i++) press(2, 24);
        chk("count_wrap", press_count, 0);
        press(2, 3);
        press(2, 30);
        press(2, 3);
        press(2, 30);
        chk("run_wrap", run_mode, 0);

        // press_in already high when reset releases
        @(negedge clk);
        rst_n = 1'b0;
        press_in = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        press_in = 1'b0;
        repeat (40) @(negedge clk);

        for (int i = 0; i < 300; i++) begin
            press($urandom_range(1, 30), $urandom_range(1, 40));
        end

        repeat (40) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/press_decoder.md
# press_decoder

Press decoder for the debounced push-button path. It consumes the one-slow-period press pulse from the debouncer and brings it into the 100 MHz `clk` domain. It reduces each press to a single-cycle event and classifies presses as single or double using a timing window. It drives lab-board control: `step_en` single-steps the processor, and a double press toggles `run_mode`.

## Interface
- `WINDOW_CYCLES`, default 50_000_000: double-press window in `clk` cycles (0.5 s at 100 MHz). Legal range is 2 to 2^`CNT_W`-1.
- `CNT_W`, default 26: window timer width.
- `clk`, in, 1: system clock (100 MHz). This is the only clock.
- `rst_n`, in, 1: reset, asynchronous and active-low. Every register clears immediately on assertion.
- `press_in`, in, 1: debouncer press pulse.
  - High for one slow-clock period (about 250 000 `clk` cycles).
  - Generated from a divided clock, so it is treated as asynchronous.
- `single_press`, out, 1: one-cycle pulse marking a single press with no second press inside the window.
- `double_press`, out, 1: one-cycle pulse marking a second press inside the window.
- `step_en`, out, 1: one-cycle pulse, equal to `single_press` while `run_mode`=0.
- `run_mode`, out, 1: level output that toggles on every `double_press`.
- `press_count`, out, 8: total detected presses, modulo 256.
- `busy`, out, 1: high while a window is open (state WAIT2).

## Operation
- **Synchronizer:** `press_in` passes through a 2-FF chain (s1, s2), then a history FF (s3).
- **Edge detect:** edge = s2 & ~s3. Exactly one edge occurs per press, regardless of pulse length. Level-high duration is ignored.
- **FSM, 2 states, registered outputs:**
  - IDLE:
    - On edge: go to WAIT2 and clear the timer to 0.
    - Otherwise: hold.
  - WAIT2:
    - The timer increments every cycle.
    - On edge: assert `double_press`, toggle `run_mode`, go to IDLE.
    - Otherwise, when timer == `WINDOW_CYCLES`-1: assert `single_press`, go to IDLE.
    - Edge and timeout on the same cycle: the edge wins, producing a double press and no single press.
- **After a double press:** the FSM returns to IDLE with no holdoff. A third press opens a new window.
- **`press_count`:** increments by 1 on every edge, in either state, and wraps from 255 to 0.
- **`step_en`:** registered alongside `single_press`. It uses the `run_mode` value from before that same clock edge.
- **`single_press` and `double_press`:** mutually exclusive, and never high on consecutive cycles from the same window.
- **Reset mid-window:** the FSM returns to IDLE and the timer to 0. Nothing is emitted, and the pending press is discarded.
- **`press_in` high at reset release:** s3 is 0, so exactly one edge is detected two cycles later. This is the required behaviour.
- **Timer width:** `CNT_W` must hold `WINDOW_CYCLES`-1. The timer never wraps because it is cleared on exit.

## Timing
- **Reset values:**
  - `single_press`=0, `double_press`=0, `step_en`=0.
  - `run_mode`=0, `press_count`=0, `busy`=0.
  - s1, s2, s3 = 0; state = IDLE; timer = 0.
- **Press to edge:** when `press_in` is first sampled high at clock edge N, the edge is high in the cycle after edge N+1.
- **Edge to state:** state, `busy` and `press_count` update at edge N+2.
- **Double press latency:** if the second press is sampled at edge M, `double_press` and the `run_mode` toggle register at edge M+2.
- **Single press latency:** if WAIT2 is entered at edge E, `single_press` and `step_en` register at edge E+`WINDOW_CYCLES`.
  - `busy` falls on that same edge.
- **Pulse width:** all event pulses last exactly one `clk` cycle.
- **Pulse spacing:** a second press is detectable only once s2 has returned low, which requires at least one low `press_in` sample.

## Test plan
Use `WINDOW_CYCLES`=20 for all scenarios.
- **Reset:** assert `rst_n` low asynchronously mid-cycle → all outputs go to 0 immediately.
- **Single press:**
  - Stimulus: `press_in` high for 50 cycles, then low.
  - Required: `busy` rises 2 cycles after the first high sample.
  - Required: `single_press`=1 and `step_en`=1 for one cycle, 20 cycles after `busy` rises.
  - Required: `press_count`=1.
- **Double press:**
  - Stimulus: two 5-cycle pulses whose first samples are 10 cycles apart.
  - Required: `double_press` fires 2 cycles after the second rise, and `single_press` never fires.
  - Required: `run_mode` goes 0→1 and `press_count`=2.
  - Follow-up: a later single press gives `single_press`=1 with `step_en`=0.
- **Boundary:** second edge coincides with timer == 19 → `double_press` only. Second edge one cycle later → `single_press` first, then a new window opens.
- **Wrap:** 256 spaced single presses → `press_count` returns to 0. Two double presses → `run_mode` returns to 0.
- **Reset mid-window:**
  - Stimulus: pulse `rst_n` low 5 cycles after a press.
  - Required: no event pulse, `busy`=0 and `press_count`=0.
  - Required: the next press behaves as a fresh single press.
